// File: rtl/m_mmio_uart.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, STATUS/DIV registers, registered reads.
// Optional free-running cycle counter at index 3 when MMIO_UART_CYCLE_CNT_EN is defined.
module m_mmio_uart #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_sel,
  input  logic [1:0]  w_addr,
  input  logic        w_we,
  input  logic [31:0] w_din,
  output logic [31:0] r_dout,
  output logic        r_txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            txd_q, txd_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [31:0]     dout_q, dout_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            wr_txdata, wr_status, wr_div;
  logic            full, empty, busy, bit_end;
  logic            pop, push_ok;
  logic [7:0]      head;
  logic [4:0]      count5;
  logic [31:0]     status;
  logic [31:0]     cyc_rd;
  logic            unused_din;

  // A divisor of zero would never reach a bit boundary, so it runs as one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  assign wr_txdata  = w_sel & w_we & (w_addr == 2'd0);
  assign wr_status  = w_sel & w_we & (w_addr == 2'd1);
  assign wr_div     = w_sel & w_we & (w_addr == 2'd2);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign bit_end    = (cnt_q == 16'd1);
  assign head       = mem[rptr_q];
  assign count5     = 5'(count_q);
  assign status     = {23'd0, count5, ovf_q, empty, full, busy};
  assign unused_din = ^w_din[31:16];

`ifdef MMIO_UART_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic        wr_cyc;

  assign wr_cyc = w_sel & w_we & (w_addr == 2'd3);
  assign cyc_d  = wr_cyc ? 32'd0 : cyc_q + 32'd1;
  assign cyc_rd = cyc_q;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) cyc_q <= 32'd0;
    else       cyc_q <= cyc_d;
  end
`else
  assign cyc_rd = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = eff_div(div_q);
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = eff_div(div_q);
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = eff_div(div_q);
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            cnt_d   = eff_div(div_q);
            bit_d   = 3'd0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    push_ok = wr_txdata & (~full | pop);
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_status && w_din[3]) ovf_d = 1'b0;
    if (wr_txdata && !push_ok) ovf_d = 1'b1;
    div_d = wr_div ? w_din[15:0] : div_q;
  end

  always_comb begin
    dout_d = 32'd0;
    if (w_sel && !w_we) begin
      unique case (w_addr)
        2'd0:    dout_d = 32'd0;
        2'd1:    dout_d = status;
        2'd2:    dout_d = {16'd0, div_q};
        default: dout_d = cyc_rd;
      endcase
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd1;
      bit_q   <= 3'd0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_DEFAULT;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge w_clk) begin
    shreg_q <= shreg_d;
    if (push_ok) mem[wptr_q] <= w_din[7:0];
  end

  assign r_dout = dout_q;
  assign r_txd  = txd_q;

endmodule
